// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: runs the request-to-send handshake, shifts one command
// byte out on device clock edges through open-drain enables, and checks the device ACK.
`timescale 1ns / 1ps

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    // Deciding one count early lands the error pulse TIMEOUT_CYCLES after the last clear.
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRelease,
        StFrame,
        StWaitIdle,
        StDone,
        StError
    } state_e;

    state_e          state;
    logic            clk_s1, clk_sync, clk_prev;
    logic            dat_s1, dat_sync;
    logic [8:0]      shift;
    logic [InhW-1:0] inh_cnt;
    logic [ToW-1:0]  tout;
    logic [3:0]      edge_cnt;
    logic            clk_fall;

    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            clk_s1       <= 1'b1;
            clk_sync     <= 1'b1;
            clk_prev     <= 1'b1;
            dat_s1       <= 1'b1;
            dat_sync     <= 1'b1;
            shift        <= '0;
            inh_cnt      <= '0;
            tout         <= '0;
            edge_cnt     <= '0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            clk_s1   <= ps2_clock_in;
            clk_sync <= clk_s1;
            clk_prev <= clk_sync;
            dat_s1   <= ps2_data_in;
            dat_sync <= dat_s1;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            case (state)
                StIdle: begin
                    if (tx_start) begin
                        shift        <= {~^tx_data, tx_data};
                        tx_busy      <= 1'b1;
                        ps2_clock_oe <= 1'b1;
                        ps2_data_oe  <= (INHIBIT_CYCLES == 1);
                        inh_cnt      <= '0;
                        state        <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (inh_cnt == InhLast) begin
                        ps2_clock_oe <= 1'b0;
                        state        <= StRelease;
                    end else begin
                        inh_cnt <= inh_cnt + InhW'(1);
                        // Start bit goes out during the final inhibit cycle.
                        if (inh_cnt + InhW'(1) == InhLast) ps2_data_oe <= 1'b1;
                    end
                end
                StRelease: begin
                    edge_cnt <= '0;
                    tout     <= '0;
                    state    <= StFrame;
                end
                StFrame: begin
                    if (clk_fall) begin
                        tout     <= '0;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt <= 4'd8) begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= shift >> 1;
                        end else if (edge_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                        end else if (dat_sync) begin
                            tx_error     <= 1'b1;
                            ps2_clock_oe <= 1'b0;
                            ps2_data_oe  <= 1'b0;
                            state        <= StError;
                        end else begin
                            state <= StWaitIdle;
                        end
                    end else if (tout == ToLast) begin
                        tx_error     <= 1'b1;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= StError;
                    end else begin
                        tout <= tout + ToW'(1);
                    end
                end
                StWaitIdle: begin
                    if (clk_sync && dat_sync) begin
                        tx_done <= 1'b1;
                        state   <= StDone;
                    end else if (clk_fall) begin
                        tout <= '0;
                    end else if (tout == ToLast) begin
                        tx_error     <= 1'b1;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= StError;
                    end else begin
                        tout <= tout + ToW'(1);
                    end
                end
                StDone, StError: begin
                    tx_busy <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    tx_busy      <= 1'b0;
                    state        <= StIdle;
                end
            endcase
        end
    end

endmodule
